// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: default frame/oversampling constants (also used
// by the transmitter) and the receiver FSM state type.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Bus-side byte output of the UART receiver.
//   rx_data   : received byte, valid while rx_valid
//   rx_valid  : byte available, held until accepted
//   rx_ready  : consumer accepts rx_data this cycle
//   frame_err : 1-clk pulse, stop bit sampled low
//   overrun   : 1-clk pulse, good frame dropped because previous byte pending
// master = receiver side, slave = consumer side.
// ----------------------------------------------------------------------------
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_sync2.sv
// ----------------------------------------------------------------------------
// uart_sync2
// Generic 2-flop synchronizer for an asynchronous single-bit input.
//   clk   : destination clock
//   reset : synchronous, active-high; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (2 clk latency)
// ----------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1-style UART receiver (LSB first) driven by a OVERSAMPLE x baud tick.
//   clk      : system clock
//   reset    : synchronous, active-high
//   rxclk_en : one-cycle tick at OVERSAMPLE x baud
//   rx       : asynchronous serial line, idle high
//   bus      : byte output (valid/ready) plus frame_err / overrun pulses
// All outputs are registered; rx_ready only feeds flop inputs.
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxclk_en,
    input  logic       rx,
    uart_rx_if.master  bus
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;

    // START samples half a bit in; DATA/STOP sample one full bit later,
    // which lands in the middle of every following bit.
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_e       state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 ovr_q;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // Handshake drop; a byte loaded below in the same cycle wins.
            if (valid_q && bus.rx_ready)
                valid_q <= 1'b0;

            if (rxclk_en) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end

                    START: begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            // line back high at mid start bit: glitch, drop it
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (tick_cnt == TICK_END) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST)
                                state <= STOP;
                            else
                                bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (tick_cnt == TICK_END) begin
                            // back to IDLE mid stop bit so a following
                            // start edge is caught without a gap
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (rx_s) begin
                                if (!valid_q || bus.rx_ready) begin
                                    data_q  <= shreg;
                                    valid_q <= 1'b1;
                                end else begin
                                    ovr_q <= 1'b1;
                                end
                            end else begin
                                ferr_q <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

endmodule
